// File: rtl/tc2sm_serial.sv
// Two's-complement to signed-magnitude converter with valid/ready handshakes.
// Negative words are negated bit-serially, LSB first, one bit per cycle.
module tc2sm_serial #(
    parameter int unsigned width = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] tc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] sm_out,
    output logic             overflow
);

    localparam int unsigned cw = $clog2(width);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [width-2:0] tc_reg;
    logic [width-2:0] mag, mag_nx;
    logic [cw-1:0]    cnt;
    logic             seen_one;
    logic             bit_in, bit_out, seen_nx, last;

    // Copy bits up to and including the first 1, invert every later bit.
    always_comb begin
        bit_in      = tc_reg[cnt];
        bit_out     = seen_one ? ~bit_in : bit_in;
        seen_nx     = seen_one | bit_in;
        last        = (cnt == cw'(width - 2));
        mag_nx      = mag;
        mag_nx[cnt] = bit_out;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = tc_in[width-1] ? SHIFT : DONE;
            end
            SHIFT: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tc_reg   <= '0;
            mag      <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            sm_out   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tc_reg   <= tc_in[width-2:0];
                        mag      <= '0;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                        if (!tc_in[width-1]) begin
                            sm_out   <= tc_in;
                            overflow <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    mag      <= mag_nx;
                    cnt      <= cnt + cw'(1);
                    seen_one <= seen_nx;
                    if (last) begin
                        // No 1 seen at all: input was the most negative value.
                        if (!seen_nx) begin
                            sm_out   <= '1;
                            overflow <= 1'b1;
                        end else begin
                            sm_out   <= {1'b1, mag_nx};
                            overflow <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tc2sm_serial.sv
// Bench for tc2sm_serial: directed vector table, backpressure and reset
// sequences, and a random stream checked against a TC-to-SM reference model.
module tb_tc2sm_serial;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] tc_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sm_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    logic [W:0] q[$];

    typedef struct {
        logic [W-1:0] tc;
        logic [W-1:0] sm;
        logic         ovf;
        int           lat;
    } vec_t;

    tc2sm_serial #(.width(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tc_in     (tc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sm_out    (sm_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] tc);
        logic [W-1:0] neg;
        if (!tc[W-1]) return {1'b0, tc};
        if (tc == {1'b1, {(W-1){1'b0}}}) return {1'b1, {W{1'b1}}};
        neg = -tc;
        return {2'b01, neg[W-2:0]};
    endfunction

    // Drives one word from IDLE with out_ready high, checks latency and result.
    task automatic run_word(input string name, input logic [W-1:0] tc,
                            input logic [W-1:0] esm, input logic eovf, input int elat);
        int lat;
        logic [W:0] exp;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        tc_in     = tc;
        out_ready = 1'b1;
        q.push_back({eovf, esm});
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        tc_in    = '0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_out_valid"}, 64'(out_valid), 64'(1));
        check({name, "_latency"}, 64'(lat), 64'(elat));
        if (q.size() == 0) begin
            check({name, "_queue"}, 64'(0), 64'(1));
        end else begin
            exp = q.pop_front();
            check({name, "_result"}, 64'({overflow, sm_out}), 64'(exp));
        end
        @(negedge clk);
        check({name, "_drop_valid"}, 64'(out_valid), 64'(0));
        check({name, "_ready_back"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;
        int   sent, rcvd, cyc;
        logic [W:0] exp;

        vecs[0] = '{tc: 11'h005, sm: 11'h005, ovf: 1'b0, lat: 1};
        vecs[1] = '{tc: 11'h000, sm: 11'h000, ovf: 1'b0, lat: 1};
        vecs[2] = '{tc: 11'h7FB, sm: 11'h405, ovf: 1'b0, lat: 11};
        vecs[3] = '{tc: 11'h7FF, sm: 11'h401, ovf: 1'b0, lat: 11};
        vecs[4] = '{tc: 11'h401, sm: 11'h7FF, ovf: 1'b0, lat: 11};
        vecs[5] = '{tc: 11'h400, sm: 11'h7FF, ovf: 1'b1, lat: 11};
        vecs[6] = '{tc: 11'h3FF, sm: 11'h3FF, ovf: 1'b0, lat: 1};
        vecs[7] = '{tc: 11'h600, sm: 11'h600, ovf: 1'b0, lat: 11};
        vecs[8] = '{tc: 11'h402, sm: 11'h7FE, ovf: 1'b0, lat: 11};
        vecs[9] = '{tc: 11'h001, sm: 11'h001, ovf: 1'b0, lat: 1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        tc_in     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sm_out", 64'(sm_out), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_word($sformatf("vec%0d", i), vecs[i].tc, vecs[i].sm, vecs[i].ovf, vecs[i].lat);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        in_valid  = 1'b1;
        tc_in     = 11'h7FB;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("bp_out_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            tc_in    = W'($urandom);
            @(negedge clk);
            check("bp_hold", 64'({out_valid, in_ready, overflow, sm_out}), 64'({3'b100, 11'h405}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid), 64'(0));
        check("bp_release_ready", 64'(in_ready), 64'(1));
        check("bp_no_capture", 64'(sm_out), 64'(11'h405));
        out_ready = 1'b0;

        // Reset in the middle of SHIFT.
        @(negedge clk);
        in_valid = 1'b1;
        tc_in    = 11'h7FB;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mrst_sm_out", 64'(sm_out), 64'(0));
        check("mrst_out_valid", 64'(out_valid), 64'(0));
        check("mrst_overflow", 64'(overflow), 64'(0));
        check("mrst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_word("after_rst", 11'h003, 11'h003, 1'b0, 1);

        // Random stream through the scoreboard.
        q.delete();
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0:       tc_in = 11'h400;
                1:       tc_in = 11'h000;
                2:       tc_in = 11'h7FF;
                default: tc_in = W'($urandom);
            endcase
            out_ready = ($urandom_range(0, 9) < 7);
            if (in_valid && in_ready) begin
                q.push_back(model(tc_in));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected", 64'(1), 64'(0));
                end else begin
                    exp = q.pop_front();
                    check("stream_result", 64'({overflow, sm_out}), 64'(exp));
                end
                rcvd++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(rcvd), 64'(1000));
        check("stream_leftover", 64'(q.size()), 64'(0));
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
